// File: rtl/ptmch_pkg.sv
// ptmch_pkg
// Shared definitions for the SPI-NAND command monitor: opcode constants,
// command index enum, FSM state enum and the opcode decoder.
package ptmch_pkg;

  localparam int P_CMD_NUM = 5;

  localparam logic [7:0] OP_PRGEXCT  = 8'h10;
  localparam logic [7:0] OP_RDSTAT_A = 8'h0F;
  localparam logic [7:0] OP_RDSTAT_B = 8'h05;
  localparam logic [7:0] OP_BLKERS   = 8'hD8;
  localparam logic [7:0] OP_PDREAD   = 8'h13;
  localparam logic [7:0] OP_WRSTAT_A = 8'h1F;
  localparam logic [7:0] OP_WRSTAT_B = 8'h01;

  // Command index doubles as the counter / TRG_PLS bit index.
  typedef enum logic [2:0] {
    CMD_PRGEXCT = 3'd0,
    CMD_RDSTAT  = 3'd1,
    CMD_BLKERS  = 3'd2,
    CMD_PDREAD  = 3'd3,
    CMD_WRSTAT  = 3'd4,
    CMD_NONE    = 3'd7
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OPCODE = 3'd1,
    ST_ADDR   = 3'd2,
    ST_EVAL   = 3'd3,
    ST_SKIP   = 3'd4
  } state_e;

  function automatic cmd_e decode_op(input logic [7:0] op);
    cmd_e cmd;
    case (op)
      OP_PRGEXCT:               cmd = CMD_PRGEXCT;
      OP_RDSTAT_A, OP_RDSTAT_B: cmd = CMD_RDSTAT;
      OP_BLKERS:                cmd = CMD_BLKERS;
      OP_PDREAD:                cmd = CMD_PDREAD;
      OP_WRSTAT_A, OP_WRSTAT_B: cmd = CMD_WRSTAT;
      default:                  cmd = CMD_NONE;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/ptmch_win_cnt.sv
// ptmch_win_cnt
// One address-window match counter. During the eval strobe, if this
// command was decoded and LOW <= addr <= HIGH (unsigned), the 32-bit
// counter increments (wrapping) and trg_o pulses for one cycle.
// Ports: clk_i, rst_n_i (async active-low), eval_i, hit_i, addr_i[23:0],
//        low_i[23:0], high_i[23:0], cnt_clr_i -> cnt_o[31:0], trg_o.
module ptmch_win_cnt (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        eval_i,
  input  logic        hit_i,
  input  logic [23:0] addr_i,
  input  logic [23:0] low_i,
  input  logic [23:0] high_i,
  input  logic        cnt_clr_i,
  output logic [31:0] cnt_o,
  output logic        trg_o
);

  logic        match_s;
  logic [31:0] cnt_d;
  logic [31:0] cnt_q;
  logic        trg_q;

  // Window compare and next counter value; clear wins over increment.
  always_comb begin
    match_s = eval_i & hit_i & (addr_i >= low_i) & (addr_i <= high_i);
    cnt_d   = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = 32'd0;
    end else if (match_s) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Registered counter and match strobe.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= 32'd0;
      trg_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      trg_q <= match_s;
    end
  end

  assign cnt_o = cnt_q;
  assign trg_o = trg_q;

endmodule

// File: rtl/ptmch_cmd_mon.sv
// ptmch_cmd_mon
// SPI-NAND bus snooper. Synchronizes CS_N/SCK/MOSI, decodes the opcode
// of each frame, captures up to 24 following address bits and hands the
// address to five window counters (one per command).
// Ports: CLK100M, RESET_N (async active-low), SPI_CS_N/SPI_SCK/SPI_MOSI
//        (async), CNT_CLR, five LOW/HIGH 24-bit windows,
//        five 32-bit counters, TRG_PLS[4:0].
module ptmch_cmd_mon
  import ptmch_pkg::*;
#(
  parameter int P_SYNC_STAGES = 2
) (
  input  logic        RESET_N,
  input  logic        CLK100M,
  input  logic        SPI_CS_N,
  input  logic        SPI_SCK,
  input  logic        SPI_MOSI,
  input  logic        CNT_CLR,
  input  logic [23:0] PRGEXCT_LOW_ADDR,
  input  logic [23:0] PRGEXCT_HIGH_ADDR,
  input  logic [23:0] RDSTAT_LOW_ADDR,
  input  logic [23:0] RDSTAT_HIGH_ADDR,
  input  logic [23:0] BLKERS_LOW_ADDR,
  input  logic [23:0] BLKERS_HIGH_ADDR,
  input  logic [23:0] PDREAD_LOW_ADDR,
  input  logic [23:0] PDREAD_HIGH_ADDR,
  input  logic [23:0] WRSTAT_LOW_ADDR,
  input  logic [23:0] WRSTAT_HIGH_ADDR,
  output logic [31:0] PRGEXCT,
  output logic [31:0] RDSTAT,
  output logic [31:0] BLKERS,
  output logic [31:0] PDREAD,
  output logic [31:0] WRSTAT,
  output logic [4:0]  TRG_PLS
);

  logic [P_SYNC_STAGES-1:0] cs_sync_q;
  logic [P_SYNC_STAGES-1:0] sck_sync_q;
  logic [P_SYNC_STAGES-1:0] mosi_sync_q;
  logic [P_SYNC_STAGES-1:0] warm_q;
  logic                     cs_prev_q;
  logic                     sck_prev_q;
  logic                     cs_armed_q;

  logic cs_s;
  logic sck_s;
  logic mosi_s;
  logic sck_rise_s;
  logic cs_fall_s;

  state_e      state_q;
  logic [4:0]  bit_cnt_q;
  logic [7:0]  op_q;
  logic [23:0] addr_q;
  cmd_e        cmd_q;
  logic [7:0]  op_next_s;
  cmd_e        op_cmd_s;
  logic        eval_s;

  // Input synchronizers plus a warm-up chain that marks when the
  // synchronizer outputs carry real pin values rather than reset values.
  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) begin
      cs_sync_q   <= {P_SYNC_STAGES{1'b1}};
      sck_sync_q  <= {P_SYNC_STAGES{1'b0}};
      mosi_sync_q <= {P_SYNC_STAGES{1'b0}};
      warm_q      <= {P_SYNC_STAGES{1'b0}};
    end else begin
      cs_sync_q   <= {cs_sync_q[P_SYNC_STAGES-2:0], SPI_CS_N};
      sck_sync_q  <= {sck_sync_q[P_SYNC_STAGES-2:0], SPI_SCK};
      mosi_sync_q <= {mosi_sync_q[P_SYNC_STAGES-2:0], SPI_MOSI};
      warm_q      <= {warm_q[P_SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign cs_s   = cs_sync_q[P_SYNC_STAGES-1];
  assign sck_s  = sck_sync_q[P_SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[P_SYNC_STAGES-1];

  // Edge-detect history. CS_N falls are only honoured after a genuine
  // synchronized high has been seen, so a reset release in the middle of
  // a frame (CS_N already low) never starts decoding mid-frame.
  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) begin
      cs_prev_q  <= 1'b1;
      sck_prev_q <= 1'b0;
      cs_armed_q <= 1'b0;
    end else begin
      cs_prev_q  <= cs_s;
      sck_prev_q <= sck_s;
      cs_armed_q <= cs_armed_q | (warm_q[P_SYNC_STAGES-1] & cs_s);
    end
  end

  assign sck_rise_s = sck_s & ~sck_prev_q;
  assign cs_fall_s  = cs_armed_q & cs_prev_q & ~cs_s;

  // Opcode value including the bit arriving this cycle, and its decode.
  always_comb begin
    op_next_s = {op_q[6:0], mosi_s};
    op_cmd_s  = decode_op(op_next_s);
  end

  // Frame FSM. A bit arriving together with CS_N high is shifted first,
  // then the CS_N rise is acted on.
  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 5'd0;
      op_q      <= 8'd0;
      addr_q    <= 24'd0;
      cmd_q     <= CMD_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall_s) begin
            state_q   <= ST_OPCODE;
            bit_cnt_q <= 5'd0;
            op_q      <= 8'd0;
          end
        end
        ST_OPCODE: begin
          if (sck_rise_s) begin
            op_q <= op_next_s;
            if (bit_cnt_q == 5'd7) begin
              cmd_q     <= op_cmd_s;
              bit_cnt_q <= 5'd0;
              addr_q    <= 24'd0;
              if (op_cmd_s == CMD_NONE) begin
                state_q <= cs_s ? ST_IDLE : ST_SKIP;
              end else begin
                state_q <= cs_s ? ST_EVAL : ST_ADDR;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (cs_s) begin
                state_q <= ST_IDLE;
              end
            end
          end else if (cs_s) begin
            state_q <= ST_IDLE;
          end
        end
        ST_ADDR: begin
          // Bits land left-aligned, so a short frame leaves zeros below.
          if (sck_rise_s) begin
            addr_q[5'd23 - bit_cnt_q] <= mosi_s;
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if ((bit_cnt_q == 5'd23) || cs_s) begin
              state_q <= ST_EVAL;
            end
          end else if (cs_s) begin
            state_q <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          state_q <= cs_s ? ST_IDLE : ST_SKIP;
        end
        ST_SKIP: begin
          if (cs_s) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign eval_s = (state_q == ST_EVAL);

  logic [23:0] low_s  [P_CMD_NUM];
  logic [23:0] high_s [P_CMD_NUM];
  logic [31:0] cnt_s  [P_CMD_NUM];

  assign low_s[0]  = PRGEXCT_LOW_ADDR;
  assign high_s[0] = PRGEXCT_HIGH_ADDR;
  assign low_s[1]  = RDSTAT_LOW_ADDR;
  assign high_s[1] = RDSTAT_HIGH_ADDR;
  assign low_s[2]  = BLKERS_LOW_ADDR;
  assign high_s[2] = BLKERS_HIGH_ADDR;
  assign low_s[3]  = PDREAD_LOW_ADDR;
  assign high_s[3] = PDREAD_HIGH_ADDR;
  assign low_s[4]  = WRSTAT_LOW_ADDR;
  assign high_s[4] = WRSTAT_HIGH_ADDR;

  for (genvar gi = 0; gi < P_CMD_NUM; gi++) begin : g_cmd
    ptmch_win_cnt u_win (
      .clk_i     (CLK100M),
      .rst_n_i   (RESET_N),
      .eval_i    (eval_s),
      .hit_i     (cmd_q == cmd_e'(gi)),
      .addr_i    (addr_q),
      .low_i     (low_s[gi]),
      .high_i    (high_s[gi]),
      .cnt_clr_i (CNT_CLR),
      .cnt_o     (cnt_s[gi]),
      .trg_o     (TRG_PLS[gi])
    );
  end

  assign PRGEXCT = cnt_s[0];
  assign RDSTAT  = cnt_s[1];
  assign BLKERS  = cnt_s[2];
  assign PDREAD  = cnt_s[3];
  assign WRSTAT  = cnt_s[4];

endmodule
